// File: rtl/beam_mux.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : beam_mux                                                        |
// | Purpose  : Packet demultiplexer from one stream source to three beam DAC   |
// |            channels. Each packet goes into a per-channel FIFO. The FIFO is |
// |            chosen by dac_sel (fixed channel or round-robin) and is latched |
// |            on the packet's first beat. Each FIFO plays out one word per    |
// |            clock once a complete packet is stored, or once it is full      |
// |            (cut-through).                                                  |
// | Ports    : clk          - single rising-edge clock                          |
// |            rst          - asynchronous reset, active low                    |
// |            dac_sel      - 00 round-robin, 01/10/11 fixed DAC1/DAC2/DAC3     |
// |            mod_t_*      - input stream (data/valid/ready/last)             |
// |            dacN_t_data  - registered DAC output word, N = 1..3            |
// |            dacN_t_valid - registered DAC word valid, N = 1..3             |
// | Options  : `define BEAM_MUX_ZERO_IDLE_EN drives dacN_t_data to 0 while     |
// |            valid is low. Without it, data holds the last word played.     |
// | Revision : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
module beam_mux #(
    parameter int N_BEAM_MUX_DACS = 3,
    parameter int FIFO_AW         = 10,
    parameter int DATA_W          = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        dac_sel,
    input  logic [DATA_W-1:0] mod_t_data,
    input  logic              mod_t_valid,
    output logic              mod_t_ready,
    input  logic              mod_t_last,
    output logic [DATA_W-1:0] dac1_t_data,
    output logic              dac1_t_valid,
    output logic [DATA_W-1:0] dac2_t_data,
    output logic              dac2_t_valid,
    output logic [DATA_W-1:0] dac3_t_data,
    output logic              dac3_t_valid
);

    // Active channel count clamped to 1..3. Channels at or above it are never targeted.
    localparam int               c_NACT    = (N_BEAM_MUX_DACS > 3) ? 3 :
                                             ((N_BEAM_MUX_DACS < 1) ? 1 : N_BEAM_MUX_DACS);
    localparam logic [1:0]       c_LAST_CH = 2'(c_NACT - 1);
    localparam logic [FIFO_AW:0] c_DEPTH   = {1'b1, {FIFO_AW{1'b0}}};

    localparam logic [0:0] c_ST_IDLE  = 1'b0;
    localparam logic [0:0] c_ST_DRAIN = 1'b1;

    logic       r_in_pkt;
    logic       r_tgt_rr;
    logic [1:0] r_tgt;
    logic [1:0] r_rr;
    logic [1:0] w_fix_ch;
    logic [1:0] w_tgt;
    logic       w_is_rr;
    logic       w_accept;
    logic [2:0] w_nfull;

    // Target resolution: the latched target applies mid-packet. Between packets,
    // the target follows dac_sel live. A fixed select beyond the active range
    // folds onto the last active channel.
    always_comb begin
        w_fix_ch = dac_sel - 2'd1;
        if (w_fix_ch > c_LAST_CH) begin
            w_fix_ch = c_LAST_CH;
        end
        w_is_rr = r_in_pkt ? r_tgt_rr : (dac_sel == 2'b00);
        if (r_in_pkt) begin
            w_tgt = r_tgt;
        end else if (dac_sel == 2'b00) begin
            w_tgt = r_rr;
        end else begin
            w_tgt = w_fix_ch;
        end
    end

    // Each not-full flag is registered per FIFO, so ready never depends on valid.
    assign mod_t_ready = w_nfull[w_tgt];
    assign w_accept    = mod_t_valid && mod_t_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_in_pkt <= 1'b0;
            r_tgt_rr <= 1'b0;
            r_tgt    <= 2'd0;
            r_rr     <= 2'd0;
        end else if (w_accept) begin
            if (!r_in_pkt) begin
                r_tgt    <= w_tgt;
                r_tgt_rr <= (dac_sel == 2'b00);
            end
            r_in_pkt <= !mod_t_last;
            if (mod_t_last && w_is_rr) begin
                r_rr <= (r_rr == c_LAST_CH) ? 2'd0 : r_rr + 2'd1;
            end
        end
    end

    for (genvar gi = 0; gi < 3; gi++) begin : g_ch
        // Each entry stores {last, data}. The last flag ends a drain burst.
        logic [DATA_W:0]     r_mem [2**FIFO_AW];
        logic [FIFO_AW-1:0]  r_wptr;
        logic [FIFO_AW-1:0]  r_rptr;
        logic [FIFO_AW:0]    r_cnt;
        logic [FIFO_AW:0]    r_pkts;
        logic [FIFO_AW:0]    w_cnt_nxt;
        logic                r_nfull;
        logic [0:0]          r_state;
        logic                w_wr;
        logic                w_rd;
        logic                w_rd_last;
        logic                w_start;
        logic                r_rd_vld;
        logic [DATA_W-1:0]   r_rd_data;
        logic                r_out_vld;
        logic [DATA_W-1:0]   r_out_data;

        assign w_wr      = w_accept && (w_tgt == 2'(gi));
        assign w_rd_last = r_mem[r_rptr][DATA_W];
        // A full FIFO with no complete packet still drains, so packets larger
        // than the FIFO cut through instead of deadlocking.
        assign w_start   = (r_pkts != '0) || (r_cnt == c_DEPTH);
        // The count guard only matters if the source stalls mid-packet during cut-through.
        assign w_rd      = (r_state == c_ST_DRAIN) ? (r_cnt != '0) : w_start;
        assign w_nfull[gi] = r_nfull;

        always_comb begin
            w_cnt_nxt = r_cnt;
            if (w_wr && !w_rd) begin
                w_cnt_nxt = r_cnt + (FIFO_AW+1)'(1);
            end else if (!w_wr && w_rd) begin
                w_cnt_nxt = r_cnt - (FIFO_AW+1)'(1);
            end
        end

        always_ff @(posedge clk) begin
            if (w_wr) begin
                r_mem[r_wptr] <= {mod_t_last, mod_t_data};
            end
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_wptr     <= '0;
                r_rptr     <= '0;
                r_cnt      <= '0;
                r_pkts     <= '0;
                r_nfull    <= 1'b0;
                r_state    <= c_ST_IDLE;
                r_rd_vld   <= 1'b0;
                r_rd_data  <= '0;
                r_out_vld  <= 1'b0;
                r_out_data <= '0;
            end else begin
                r_cnt   <= w_cnt_nxt;
                r_nfull <= (w_cnt_nxt != c_DEPTH);
                if (w_wr) begin
                    r_wptr <= r_wptr + FIFO_AW'(1);
                end
                if ((w_wr && mod_t_last) && !(w_rd && w_rd_last)) begin
                    r_pkts <= r_pkts + (FIFO_AW+1)'(1);
                end else if (!(w_wr && mod_t_last) && (w_rd && w_rd_last)) begin
                    r_pkts <= r_pkts - (FIFO_AW+1)'(1);
                end
                if (w_rd) begin
                    r_rptr    <= r_rptr + FIFO_AW'(1);
                    r_rd_data <= r_mem[r_rptr][DATA_W-1:0];
                    // After a last word, drop to idle. The next packet (if any)
                    // restarts on the next clock with no gap.
                    r_state   <= w_rd_last ? c_ST_IDLE : c_ST_DRAIN;
                end
                r_rd_vld  <= w_rd;
                r_out_vld <= r_rd_vld;
                if (r_rd_vld) begin
                    r_out_data <= r_rd_data;
                end else begin
`ifdef BEAM_MUX_ZERO_IDLE_EN
                    r_out_data <= '0;
`else
                    r_out_data <= r_out_data;
`endif
                end
            end
        end
    end

    assign dac1_t_data  = g_ch[0].r_out_data;
    assign dac1_t_valid = g_ch[0].r_out_vld;
    assign dac2_t_data  = g_ch[1].r_out_data;
    assign dac2_t_valid = g_ch[1].r_out_vld;
    assign dac3_t_data  = g_ch[2].r_out_data;
    assign dac3_t_valid = g_ch[2].r_out_vld;

endmodule
`default_nettype wire

// File: tb/tb_beam_mux.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_beam_mux                                                     |
// | Purpose  : Self-checking bench for beam_mux. A packet table drives the     |
// |            source. Expected words are queued per DAC channel as they are  |
// |            accepted, and compared in order as each DAC plays them out.    |
// | Revision : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
module tb_beam_mux;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  dac_sel;
    logic [31:0] mod_t_data;
    logic        mod_t_valid;
    logic        mod_t_ready;
    logic        mod_t_last;
    logic [31:0] dac1_t_data, dac2_t_data, dac3_t_data;
    logic        dac1_t_valid, dac2_t_valid, dac3_t_valid;

    beam_mux #(
        .N_BEAM_MUX_DACS(3),
        .FIFO_AW        (10),
        .DATA_W         (32)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .dac_sel     (dac_sel),
        .mod_t_data  (mod_t_data),
        .mod_t_valid (mod_t_valid),
        .mod_t_ready (mod_t_ready),
        .mod_t_last  (mod_t_last),
        .dac1_t_data (dac1_t_data),
        .dac1_t_valid(dac1_t_valid),
        .dac2_t_data (dac2_t_data),
        .dac2_t_valid(dac2_t_valid),
        .dac3_t_data (dac3_t_data),
        .dac3_t_valid(dac3_t_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] sel;
        int         len;
        int         base;
        int         ch;
        bit         stall;
    } vec_t;

    vec_t        tbl[10];
    logic [31:0] q1[$];
    logic [31:0] q2[$];
    logic [31:0] q3[$];
    int          n_vec = 0;
    int          n_err = 0;
    int          stall_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input int ch, input logic [31:0] v);
        case (ch)
            0:       q1.push_back(v);
            1:       q2.push_back(v);
            default: q3.push_back(v);
        endcase
    endtask

    // Scoreboard side: every valid DAC word must match the oldest queued word for that channel.
    always @(negedge clk) begin
        if (rst) begin
            if (dac1_t_valid) begin
                if (q1.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL dac1_extra: got word %0h, expected no output", dac1_t_data);
                end else check("dac1_word", dac1_t_data, q1.pop_front());
            end
            if (dac2_t_valid) begin
                if (q2.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL dac2_extra: got word %0h, expected no output", dac2_t_data);
                end else check("dac2_word", dac2_t_data, q2.pop_front());
            end
            if (dac3_t_valid) begin
                if (q3.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL dac3_extra: got word %0h, expected no output", dac3_t_data);
                end else check("dac3_word", dac3_t_data, q3.pop_front());
            end
        end
    end

    // Drives one packet beat by beat. Inputs change #1 after an edge. Ready is
    // sampled there too, so a beat presented while ready is high is taken at the
    // next edge. If with_last is 0, valid is left high and the packet stays open.
    task automatic send_packet(input logic [1:0] sel, input int len, input int base,
                               input int ch, input int sw_at, input logic [1:0] sw_sel,
                               input bit with_last);
        dac_sel = sel;
        for (int i = 0; i < len; i++) begin
            int guard = 0;
            mod_t_valid = 1'b1;
            mod_t_data  = base + i;
            mod_t_last  = with_last && (i == len - 1);
            while (!mod_t_ready && guard < 4000) begin
                @(posedge clk); #1;
                guard++;
                stall_cnt++;
            end
            if (!mod_t_ready) begin
                n_vec++; n_err++;
                $display("FAIL ready_timeout: ready stuck at 0 on beat %0d, expected 1", i);
                mod_t_valid = 1'b0;
                return;
            end
            push(ch, base + i);
            @(posedge clk); #1;
            if (i == sw_at) dac_sel = sw_sel;
        end
        if (with_last) begin
            mod_t_valid = 1'b0;
            mod_t_last  = 1'b0;
        end
    endtask

    task automatic wait_idle(input string tag);
        int guard = 0;
        while ((q1.size() + q2.size() + q3.size()) != 0 && guard < 5000) begin
            @(posedge clk);
            guard++;
        end
        n_vec++;
        if ((q1.size() + q2.size() + q3.size()) != 0) begin
            n_err++;
            $display("FAIL %s_drain: got %0d words outstanding, expected 0", tag,
                     q1.size() + q2.size() + q3.size());
        end
        repeat (4) @(posedge clk);
        #1;
    endtask

    initial begin
        // Packet table: one cut-through packet to DAC2, then nine round-robin packets.
        tbl[0] = '{2'b10, 2048, 32'h0000_0000, 1, 1'b1};
        for (int k = 1; k <= 9; k++) begin
            tbl[k] = '{2'b00, 1024, k << 16, (k - 1) % 3, 1'b0};
        end

        rst         = 1'b0;
        dac_sel     = 2'b01;
        mod_t_data  = '0;
        mod_t_valid = 1'b0;
        mod_t_last  = 1'b0;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", {31'd0, mod_t_ready}, 32'd0);
        check("rst_valids", {29'd0, dac1_t_valid, dac2_t_valid, dac3_t_valid}, 32'd0);
        check("rst_dac1_data", dac1_t_data, 32'd0);
        check("rst_dac2_data", dac2_t_data, 32'd0);
        check("rst_dac3_data", dac3_t_data, 32'd0);
        rst = 1'b1;
        #1;
        check("rel_ready_before_edge", {31'd0, mod_t_ready}, 32'd0);
        @(posedge clk); #1;
        check("rel_ready_after_edge", {31'd0, mod_t_ready}, 32'd1);

        // Fixed DAC1, full-depth packet: latency, contiguity, and idle data.
        send_packet(2'b01, 1024, 0, 0, -1, 2'b00, 1'b1);
        check("lat_dac1_e0", {31'd0, dac1_t_valid}, 32'd0);
        @(posedge clk); #1;
        check("lat_dac1_e1", {31'd0, dac1_t_valid}, 32'd0);
        @(posedge clk); #1;
        check("lat_dac1_e2_valid", {31'd0, dac1_t_valid}, 32'd1);
        check("lat_dac1_e2_data", dac1_t_data, 32'd0);
        wait_idle("dac1_pkt");
        check("idle_dac1_valid", {31'd0, dac1_t_valid}, 32'd0);
`ifdef BEAM_MUX_ZERO_IDLE_EN
        check("idle_dac1_data", dac1_t_data, 32'd0);
`else
        check("idle_dac1_data", dac1_t_data, 32'd1023);
`endif

        // Table-driven packets.
        for (int i = 0; i < 10; i++) begin
            stall_cnt = 0;
            send_packet(tbl[i].sel, tbl[i].len, tbl[i].base, tbl[i].ch, -1, 2'b00, 1'b1);
            check($sformatf("stall_seen_%0d", i), {31'd0, (stall_cnt != 0)}, {31'd0, tbl[i].stall});
        end
        wait_idle("table");

        // dac_sel changes mid-packet: the rest of that packet stays on DAC1, and the next packet goes to DAC3.
        send_packet(2'b01, 16, 32'h500, 0, 7, 2'b11, 1'b1);
        send_packet(2'b11, 8, 32'h600, 2, -1, 2'b11, 1'b1);
        wait_idle("switch");

        // Reset mid-stream: drop a draining DAC1 packet and an open DAC2 packet.
        send_packet(2'b01, 1024, 32'h7000, 0, -1, 2'b00, 1'b1);
        send_packet(2'b10, 100, 32'h8000, 1, -1, 2'b00, 1'b0);
        rst = 1'b0;
        #1;
        check("mid_rst_ready", {31'd0, mod_t_ready}, 32'd0);
        check("mid_rst_valids", {29'd0, dac1_t_valid, dac2_t_valid, dac3_t_valid}, 32'd0);
        check("mid_rst_dac1_data", dac1_t_data, 32'd0);
        q1.delete(); q2.delete(); q3.delete();
        mod_t_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("mid_rel_ready", {31'd0, mod_t_ready}, 32'd1);
        repeat (1100) @(posedge clk);
        #1;
        send_packet(2'b01, 4, 32'h9000, 0, -1, 2'b00, 1'b1);
        send_packet(2'b10, 4, 32'hA000, 1, -1, 2'b00, 1'b1);
        wait_idle("post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
